// File: rtl/alu_issue_ctrl_pkg.sv
// Shared definitions for the ALU issue/writeback controller: opcodes,
// instruction field positions, FSM state encoding and an opcode legality helper.
package alu_issue_ctrl_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_NREGS  = 8;
    localparam int DEF_REG_AW = 3;

    // Opcodes understood by the downstream ALU
    localparam logic [3:0] OP_AND  = 4'b1001;
    localparam logic [3:0] OP_OR   = 4'b1010;
    localparam logic [3:0] OP_XOR  = 4'b1011;
    localparam logic [3:0] OP_ADD  = 4'b0100;
    localparam logic [3:0] OP_SUB  = 4'b0101;
    localparam logic [3:0] OP_AINV = 4'b0110;
    localparam logic [3:0] OP_INC  = 4'b0111;

    // Instruction field bit positions
    localparam int OP_HI  = 15;
    localparam int OP_LO  = 12;
    localparam int RD_HI  = 11;
    localparam int RD_LO  = 9;
    localparam int RS1_HI = 8;
    localparam int RS1_LO = 6;
    localparam int RS2_HI = 5;
    localparam int RS2_LO = 3;
    localparam int RSV_HI = 2;
    localparam int RSV_LO = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_WB   = 2'b10
    } state_t;

    // True when the opcode is one the ALU implements
    function automatic logic op_is_legal(input logic [3:0] op);
        logic legal;
        case (op)
            OP_AND, OP_OR, OP_XOR, OP_ADD, OP_SUB, OP_AINV, OP_INC: legal = 1'b1;
            default: legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/alu_regfile.sv
// Register file for the ALU issue controller: one write port, three
// combinational read ports (rs1, rs2, readback). r0 always reads as zero.
module alu_regfile
    import alu_issue_ctrl_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int NREGS  = DEF_NREGS,
    parameter int REG_AW = DEF_REG_AW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [REG_AW-1:0] rs1_addr,
    output logic [DATA_W-1:0] rs1_data,
    input  logic [REG_AW-1:0] rs2_addr,
    output logic [DATA_W-1:0] rs2_data,
    input  logic [REG_AW-1:0] rb_addr,
    output logic [DATA_W-1:0] rb_data
);

    logic [DATA_W-1:0] regs_r [NREGS];

    // Register storage; writes to r0 are dropped so it stays zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_r[i] <= {DATA_W{1'b0}};
            end
        end else if (we && (waddr != {REG_AW{1'b0}})) begin
            regs_r[waddr] <= wdata;
        end
    end

    assign rs1_data = (rs1_addr == {REG_AW{1'b0}}) ? {DATA_W{1'b0}} : regs_r[rs1_addr];
    assign rs2_data = (rs2_addr == {REG_AW{1'b0}}) ? {DATA_W{1'b0}} : regs_r[rs2_addr];
    assign rb_data  = (rb_addr  == {REG_AW{1'b0}}) ? {DATA_W{1'b0}} : regs_r[rb_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Serial issue/writeback controller wrapped around a combinational ALU.
// Each instruction walks IDLE -> EXEC -> WB; only one is ever in flight.
// Optional build macro ALU_ISSUE_PERF_EN adds retired/illegal counters.
module alu_issue_ctrl
    import alu_issue_ctrl_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int NREGS  = DEF_NREGS,
    parameter int REG_AW = DEF_REG_AW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [15:0]       in_instr,
    input  logic              ld_en,
    input  logic [REG_AW-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic [REG_AW-1:0] rb_addr,
    output logic [DATA_W-1:0] rb_data,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [3:0]        alu_sel,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    output logic              done,
    output logic              err,
    output logic              zero_flag
`ifdef ALU_ISSUE_PERF_EN
    ,
    output logic [31:0]       retired_cnt,
    output logic [15:0]       illegal_cnt
`endif
);

    state_t            state_r;
    state_t            state_nxt_s;
    logic              accept_s;
    logic              in_ready_s;

    logic [3:0]        op_r;
    logic [REG_AW-1:0] rd_r;
    logic              legal_r;
    logic [DATA_W-1:0] alu_a_r;
    logic [DATA_W-1:0] alu_b_r;
    logic [3:0]        alu_sel_r;
    logic [DATA_W-1:0] res_r;
    logic              zero_cap_r;
    logic              done_r;
    logic              err_r;
    logic              zero_flag_r;

    logic              we_s;
    logic [REG_AW-1:0] waddr_s;
    logic [DATA_W-1:0] wdata_s;
    logic [DATA_W-1:0] rs1_data_s;
    logic [DATA_W-1:0] rs2_data_s;
    logic              unused_rsvd_s;

    // Reserved instruction bits carry no meaning
    assign unused_rsvd_s = ^in_instr[RSV_HI:RSV_LO];

    // Operands are read straight from the incoming instruction while idle and
    // registered on accept, so the ALU inputs are flop-driven during EXEC.
    alu_regfile #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS),
        .REG_AW (REG_AW)
    ) u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (we_s),
        .waddr    (waddr_s),
        .wdata    (wdata_s),
        .rs1_addr (in_instr[RS1_HI:RS1_LO]),
        .rs1_data (rs1_data_s),
        .rs2_addr (in_instr[RS2_HI:RS2_LO]),
        .rs2_data (rs2_data_s),
        .rb_addr  (rb_addr),
        .rb_data  (rb_data)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state and handshake; a pending load blocks acceptance for that cycle
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        in_ready_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                in_ready_s = !ld_en;
                if (in_valid && !ld_en) begin
                    accept_s    = 1'b1;
                    state_nxt_s = ST_EXEC;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_EXEC: state_nxt_s = ST_WB;
            ST_WB:   state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    assign in_ready = rst_n & in_ready_s;

    // Register-file write selection: side-band load in IDLE, result in WB
    always_comb begin
        we_s    = 1'b0;
        waddr_s = {REG_AW{1'b0}};
        wdata_s = {DATA_W{1'b0}};
        if ((state_r == ST_IDLE) && ld_en) begin
            we_s    = 1'b1;
            waddr_s = ld_addr;
            wdata_s = ld_data;
        end else if ((state_r == ST_WB) && legal_r) begin
            we_s    = 1'b1;
            waddr_s = rd_r;
            wdata_s = res_r;
        end else begin
            we_s    = 1'b0;
        end
    end

    // Instruction latch, ALU drive, result capture and retirement pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_r        <= 4'b0000;
            rd_r        <= {REG_AW{1'b0}};
            legal_r     <= 1'b0;
            alu_a_r     <= {DATA_W{1'b0}};
            alu_b_r     <= {DATA_W{1'b0}};
            alu_sel_r   <= 4'b0000;
            res_r       <= {DATA_W{1'b0}};
            zero_cap_r  <= 1'b0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
            zero_flag_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            err_r  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        op_r      <= in_instr[OP_HI:OP_LO];
                        rd_r      <= in_instr[RD_HI:RD_LO];
                        legal_r   <= op_is_legal(in_instr[OP_HI:OP_LO]);
                        alu_a_r   <= rs1_data_s;
                        alu_b_r   <= rs2_data_s;
                        alu_sel_r <= in_instr[OP_HI:OP_LO];
                    end
                end
                ST_EXEC: begin
                    res_r      <= alu_result;
                    zero_cap_r <= alu_zero;
                    done_r     <= 1'b1;
                    err_r      <= !legal_r;
                    alu_a_r    <= {DATA_W{1'b0}};
                    alu_b_r    <= {DATA_W{1'b0}};
                    alu_sel_r  <= 4'b0000;
                end
                ST_WB: begin
                    if (legal_r) begin
                        zero_flag_r <= zero_cap_r;
                    end
                end
                default: begin
                    done_r <= 1'b0;
                end
            endcase
        end
    end

    assign alu_a     = alu_a_r;
    assign alu_b     = alu_b_r;
    assign alu_sel   = alu_sel_r;
    assign done      = done_r;
    assign err       = err_r;
    assign zero_flag = zero_flag_r;

`ifdef ALU_ISSUE_PERF_EN
    logic [31:0] retired_cnt_r;
    logic [15:0] illegal_cnt_r;

    // Retirement counter wraps; illegal counter saturates
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_cnt_r <= 32'd0;
            illegal_cnt_r <= 16'd0;
        end else begin
            if (done_r) begin
                retired_cnt_r <= retired_cnt_r + 32'd1;
            end
            if (err_r && (illegal_cnt_r != 16'hFFFF)) begin
                illegal_cnt_r <= illegal_cnt_r + 16'd1;
            end
        end
    end

    assign retired_cnt = retired_cnt_r;
    assign illegal_cnt = illegal_cnt_r;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: a behavioural ALU drives the
// result inputs, a transaction-level model predicts every output each cycle,
// and directed scenarios pin specific values.
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_instr = 16'h0000;
    logic        ld_en = 1'b0;
    logic [2:0]  ld_addr = 3'd0;
    logic [31:0] ld_data = 32'd0;
    logic [2:0]  rb_addr = 3'd0;
    logic [31:0] rb_data;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_sel;
    logic [31:0] alu_result;
    logic        alu_zero;
    logic        done;
    logic        err;
    logic        zero_flag;
`ifdef ALU_ISSUE_PERF_EN
    logic [31:0] retired_cnt;
    logic [15:0] illegal_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    alu_issue_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_instr   (in_instr),
        .ld_en      (ld_en),
        .ld_addr    (ld_addr),
        .ld_data    (ld_data),
        .rb_addr    (rb_addr),
        .rb_data    (rb_data),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_sel    (alu_sel),
        .alu_result (alu_result),
        .alu_zero   (alu_zero),
        .done       (done),
        .err        (err),
        .zero_flag  (zero_flag)
`ifdef ALU_ISSUE_PERF_EN
        ,
        .retired_cnt(retired_cnt),
        .illegal_cnt(illegal_cnt)
`endif
    );

    function automatic logic [31:0] alu_f(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b);
        case (sel)
            4'b1001: return a & b;
            4'b1010: return a | b;
            4'b1011: return a ^ b;
            4'b0100: return a + b;
            4'b0101: return a - b;
            4'b0110: return ~a;
            4'b0111: return a + 32'd1;
            default: return 32'd0;
        endcase
    endfunction

    function automatic bit legal_f(input logic [3:0] op);
        return op inside {4'b1001, 4'b1010, 4'b1011, 4'b0100, 4'b0101, 4'b0110, 4'b0111};
    endfunction

    function automatic logic [15:0] mk(input logic [3:0] op, input logic [2:0] rd,
                                       input logic [2:0] rs1, input logic [2:0] rs2);
        return {op, rd, rs1, rs2, 3'b101};
    endfunction

    // Combinational ALU seen by the controller
    always_comb begin
        alu_result = alu_f(alu_sel, alu_a, alu_b);
        alu_zero   = (alu_result == 32'd0);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    logic [31:0] m_rf [8];
    bit          m_busy;
    int          m_age;
    logic [3:0]  m_op;
    logic [2:0]  m_rd;
    logic [31:0] m_a, m_b, m_res;
    bit          m_zf;
    logic [31:0] m_ret;
    int          m_ill;

    // Model advances one step per clock using the inputs present before the edge
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) m_rf[i] <= 32'd0;
            m_busy <= 1'b0; m_age <= 0; m_op <= 4'd0; m_rd <= 3'd0;
            m_a <= 32'd0; m_b <= 32'd0; m_res <= 32'd0; m_zf <= 1'b0;
            m_ret <= 32'd0; m_ill <= 0;
        end else if (!m_busy) begin
            if (ld_en) begin
                if (ld_addr != 3'd0) m_rf[ld_addr] <= ld_data;
            end else if (in_valid) begin
                m_busy <= 1'b1;
                m_age  <= 1;
                m_op   <= in_instr[15:12];
                m_rd   <= in_instr[11:9];
                m_a    <= m_rf[in_instr[8:6]];
                m_b    <= m_rf[in_instr[5:3]];
            end
        end else if (m_age == 1) begin
            m_res <= alu_f(m_op, m_a, m_b);
            m_age <= 2;
        end else begin
            if (legal_f(m_op)) begin
                if (m_rd != 3'd0) m_rf[m_rd] <= m_res;
                m_zf <= (m_res == 32'd0);
            end else if (m_ill < 65535) begin
                m_ill <= m_ill + 1;
            end
            m_ret  <= m_ret + 32'd1;
            m_busy <= 1'b0;
        end
    end

    // Every-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        bit in_exec, retiring;
        in_exec  = m_busy && (m_age == 1);
        retiring = m_busy && (m_age == 2);
        chk("in_ready", {31'd0, in_ready}, {31'd0, (rst_n && !m_busy && !ld_en)});
        chk("alu_a", alu_a, in_exec ? m_a : 32'd0);
        chk("alu_b", alu_b, in_exec ? m_b : 32'd0);
        chk("alu_sel", {28'd0, alu_sel}, in_exec ? {28'd0, m_op} : 32'd0);
        chk("done", {31'd0, done}, {31'd0, retiring});
        chk("err", {31'd0, err}, {31'd0, (retiring && !legal_f(m_op))});
        chk("zero_flag", {31'd0, zero_flag}, {31'd0, m_zf});
        chk("rb_data", rb_data, (rb_addr == 3'd0) ? 32'd0 : m_rf[rb_addr]);
`ifdef ALU_ISSUE_PERF_EN
        chk("retired_cnt", retired_cnt, m_ret);
        chk("illegal_cnt", {16'd0, illegal_cnt}, m_ill[31:0]);
`endif
    end

    // ---------------- stimulus ----------------
    task automatic load(input logic [2:0] a, input logic [31:0] d);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        @(posedge clk); #2;
        ld_en = 1'b0;
    endtask

    // Issue one instruction; report edges waited for acceptance, cycles to done, and err at done
    task automatic issue(input logic [15:0] ins, output int waits, output int lat, output logic got_err);
        bit rdy;
        bit seen;
        in_valid = 1'b1; in_instr = ins;
        waits = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk); rdy = in_ready;
            @(posedge clk); #2;
            ld_en = 1'b0;
            waits++;
            if (rdy) break;
        end
        in_valid = 1'b0;
        lat = 0; seen = 1'b0; got_err = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk); lat++;
            if (done) begin seen = 1'b1; got_err = err; break; end
        end
        chk("done_timeout", {31'd0, seen}, 32'd1);
        @(posedge clk); #2;
    endtask

    initial begin
        int w, l, seen_done;
        logic e;
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, l, seen_done;
        logic e;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_zero_flag", {31'd0, zero_flag}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        rst_n = 1'b1;
        #1 chk("ready_after_rst", {31'd0, in_ready}, 32'd1);

        load(3'd1, 32'hAF554D4E);
        load(3'd2, 32'h87AA9777);
        load(3'd6, 32'h12345678);
        load(3'd0, 32'hDEADBEEF);

        issue(mk(4'b1001, 3'd3, 3'd1, 3'd2), w, l, e);
        chk("and_latency", l, 32'd2);
        rb_addr = 3'd3; #1 chk("and_r3", rb_data, 32'h87000546);
        chk("and_zf", {31'd0, zero_flag}, 32'd0);

        issue(mk(4'b0100, 3'd4, 3'd1, 3'd2), w, l, e);
        rb_addr = 3'd4; #1 chk("add_r4", rb_data, 32'h36FFE4C5);

        issue(mk(4'b0000, 3'd6, 3'd1, 3'd2), w, l, e);
        chk("ill_err", {31'd0, e}, 32'd1);
        rb_addr = 3'd6; #1 chk("ill_r6", rb_data, 32'h12345678);
        chk("ill_zf_kept", {31'd0, zero_flag}, 32'd0);

        issue(mk(4'b0101, 3'd5, 3'd1, 3'd1), w, l, e);
        chk("sub_err", {31'd0, e}, 32'd0);
        rb_addr = 3'd5; #1 chk("sub_r5", rb_data, 32'h00000000);
        chk("sub_zf", {31'd0, zero_flag}, 32'd1);

        issue(mk(4'b0100, 3'd0, 3'd1, 3'd2), w, l, e);
        rb_addr = 3'd0; #1 chk("r0_zero", rb_data, 32'h00000000);

        issue(mk(4'b1010, 3'd6, 3'd1, 3'd2), w, l, e);
        rb_addr = 3'd6; #1 chk("or_r6", rb_data, 32'hAFFFDF7F);
        issue(mk(4'b1011, 3'd7, 3'd1, 3'd2), w, l, e);
        rb_addr = 3'd7; #1 chk("xor_r7", rb_data, 32'h28FFDA39);
        issue(mk(4'b0110, 3'd3, 3'd1, 3'd0), w, l, e);
        rb_addr = 3'd3; #1 chk("ainv_r3", rb_data, 32'h50AAB2B1);
        issue(mk(4'b0111, 3'd7, 3'd7, 3'd0), w, l, e);
        rb_addr = 3'd7; #1 chk("inc_r7_chain", rb_data, 32'h28FFDA3A);

        // Load and instruction presented together: load wins, instruction next cycle
        ld_en = 1'b1; ld_addr = 3'd5; ld_data = 32'hCAFEF00D;
        issue(mk(4'b0111, 3'd4, 3'd5, 3'd0), w, l, e);
        chk("ld_prio_waits", w, 32'd2);
        rb_addr = 3'd4; #1 chk("ld_prio_r4", rb_data, 32'hCAFEF00E);

        // Reset during EXEC aborts the instruction
        in_valid = 1'b1; in_instr = mk(4'b0100, 3'd7, 3'd1, 3'd2);
        @(posedge clk); #2;
        in_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b1;
        seen_done = 0;
        @(negedge clk);
        chk("rst_ready_1cyc", {31'd0, in_ready}, 32'd1);
        if (done) seen_done++;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (done) seen_done++;
        end
        chk("rst_no_done", seen_done, 32'd0);
        rb_addr = 3'd7; #1 chk("rst_r7", rb_data, 32'h00000000);
        @(posedge clk); #2;

        // Three legal plus one illegal instruction
        load(3'd1, 32'd5);
        load(3'd2, 32'd3);
        issue(mk(4'b0100, 3'd3, 3'd1, 3'd2), w, l, e);
        issue(mk(4'b0101, 3'd4, 3'd1, 3'd2), w, l, e);
        issue(mk(4'b1111, 3'd5, 3'd1, 3'd2), w, l, e);
        chk("ill_f_err", {31'd0, e}, 32'd1);
        issue(mk(4'b1001, 3'd6, 3'd1, 3'd2), w, l, e);
        rb_addr = 3'd4; #1 chk("sub_5_3", rb_data, 32'd2);
        rb_addr = 3'd6; #1 chk("and_5_3", rb_data, 32'd1);
`ifdef ALU_ISSUE_PERF_EN
        chk("perf_retired", retired_cnt, 32'd4);
        chk("perf_illegal", {16'd0, illegal_cnt}, 32'd1);
`endif

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
